// File: rtl/soin_alu_pkg.sv
// Shared types for the execute-stage ALU: control codes, executor states and
// the shift-op classifier used by the decoder and the iterative executor.
package soin_alu_pkg;

    typedef enum logic [3:0] {
        ADD   = 4'd0,
        SUB   = 4'd1,
        SLL   = 4'd2,
        SLT   = 4'd3,
        SLTU  = 4'd4,
        XOR   = 4'd5,
        SRL   = 4'd6,
        SRA   = 4'd7,
        OR    = 4'd8,
        AND   = 4'd9,
        LUI   = 4'd10,
        AUIPC = 4'd11
    } alu_op_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } alu_exec_state_t;

    function automatic logic is_shift(alu_op_t op);
        return (op == SLL) || (op == SRL) || (op == SRA);
    endfunction

endpackage

// File: rtl/alu_shift_step.sv
// Combinational single-bit shift of an XLEN word; the executor applies it once
// per cycle. Non-shift codes pass the word through unchanged.
module alu_shift_step
    import soin_alu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  alu_op_t          op,
    input  logic [XLEN-1:0]  data,
    output logic [XLEN-1:0]  shifted
);

    always_comb begin
        shifted = data;
        case (op)
            SLL:     shifted = {data[XLEN-2:0], 1'b0};
            SRL:     shifted = {1'b0, data[XLEN-1:1]};
            SRA:     shifted = {data[XLEN-1], data[XLEN-1:1]};
            default: shifted = data;
        endcase
    end

endmodule

// File: rtl/alu_iterative_exec.sv
// Execute-stage ALU: single-cycle logic/arith/compare ops, 1-bit-per-cycle
// shifts, valid/ready on both sides and a flush that discards in-flight work.
//
// Handshake: an op is taken on a rising edge where i_op_valid && o_op_ready;
// a result is handed off on a rising edge where o_res_valid && i_res_ready.
// o_result/o_zero/o_illegal stay stable while o_res_valid waits for the consumer.
module alu_iterative_exec
    import soin_alu_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int SHAMT_W = 5
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_op_valid,
    output logic             o_op_ready,
    input  logic [3:0]       i_alu_ctrl,
    input  logic [XLEN-1:0]  i_op_a,
    input  logic [XLEN-1:0]  i_op_b,
    input  logic             i_flush,
    output logic             o_res_valid,
    input  logic             i_res_ready,
    output logic [XLEN-1:0]  o_result,
    output logic             o_zero,
    output logic             o_illegal
);

    alu_exec_state_t     state_q, state_d;
    alu_op_t             op_q, op_d;
    logic [XLEN-1:0]     work_q, work_d;
    logic [SHAMT_W-1:0]  cnt_q, cnt_d;
    logic [XLEN-1:0]     result_q, result_d;
    logic                illegal_q, illegal_d;
    logic                zero_q;

    alu_op_t             op_in;
    logic [SHAMT_W-1:0]  shamt_in;
    logic [XLEN-1:0]     alu_res;
    logic                alu_ill;
    logic [XLEN-1:0]     step_out;

    assign op_in    = alu_op_t'(i_alu_ctrl);
    assign shamt_in = i_op_b[SHAMT_W-1:0];

    alu_shift_step #(.XLEN(XLEN)) u_shift_step (
        .op      (op_q),
        .data    (work_q),
        .shifted (step_out)
    );

    // Single-cycle datapath; codes 12-15 produce a defined zero and flag illegal.
    always_comb begin
        alu_res = '0;
        alu_ill = 1'b0;
        case (op_in)
            ADD, AUIPC: alu_res = i_op_a + i_op_b;
            SUB:        alu_res = i_op_a - i_op_b;
            SLT:        alu_res = {{(XLEN-1){1'b0}}, ($signed(i_op_a) < $signed(i_op_b))};
            SLTU:       alu_res = {{(XLEN-1){1'b0}}, (i_op_a < i_op_b)};
            XOR:        alu_res = i_op_a ^ i_op_b;
            OR:         alu_res = i_op_a | i_op_b;
            AND:        alu_res = i_op_a & i_op_b;
            LUI:        alu_res = i_op_b;
            SLL, SRL, SRA: alu_res = '0;
            default:    alu_ill = 1'b1;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        work_d    = work_q;
        cnt_d     = cnt_q;
        result_d  = result_q;
        illegal_d = illegal_q;
        case (state_q)
            IDLE: begin
                if (i_op_valid && !i_flush) begin
                    op_d = op_in;
                    if (!is_shift(op_in)) begin
                        result_d  = alu_res;
                        illegal_d = alu_ill;
                        state_d   = DONE;
                    end else if (shamt_in == '0) begin
                        result_d  = i_op_a;
                        illegal_d = 1'b0;
                        state_d   = DONE;
                    end else begin
                        work_d  = i_op_a;
                        cnt_d   = shamt_in;
                        state_d = SHIFT;
                    end
                end
            end
            SHIFT: begin
                if (i_flush) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end else begin
                    work_d = step_out;
                    cnt_d  = cnt_q - SHAMT_W'(1);
                    // The step taken at count 1 is the last one; publish it directly.
                    if (cnt_q == SHAMT_W'(1)) begin
                        result_d  = step_out;
                        illegal_d = 1'b0;
                        state_d   = DONE;
                    end
                end
            end
            DONE: begin
                if (i_flush || i_res_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q   <= IDLE;
            op_q      <= ADD;
            work_q    <= '0;
            cnt_q     <= '0;
            result_q  <= '0;
            zero_q    <= 1'b1;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            work_q    <= work_d;
            cnt_q     <= cnt_d;
            result_q  <= result_d;
            zero_q    <= (result_d == '0);
            illegal_q <= illegal_d;
        end
    end

    assign o_op_ready  = (state_q == IDLE);
    assign o_res_valid = (state_q == DONE);
    assign o_result    = result_q;
    assign o_zero      = zero_q;
    assign o_illegal   = illegal_q;

endmodule

// File: tb/tb_alu_iterative_exec.sv
// Bench for alu_iterative_exec: directed vector table, hand-written flush,
// stall and reset sequences, then random ops against an arithmetic model.
module tb_alu_iterative_exec;

  logic        i_clk;
  logic        i_rst_n;
  logic        i_op_valid;
  logic        o_op_ready;
  logic [3:0]  i_alu_ctrl;
  logic [31:0] i_op_a;
  logic [31:0] i_op_b;
  logic        i_flush;
  logic        o_res_valid;
  logic        i_res_ready;
  logic [31:0] o_result;
  logic        o_zero;
  logic        o_illegal;

  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] exp_q[$];

  alu_iterative_exec #(.XLEN(32), .SHAMT_W(5)) dut (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_op_valid  (i_op_valid),
    .o_op_ready  (o_op_ready),
    .i_alu_ctrl  (i_alu_ctrl),
    .i_op_a      (i_op_a),
    .i_op_b      (i_op_b),
    .i_flush     (i_flush),
    .o_res_valid (o_res_valid),
    .i_res_ready (i_res_ready),
    .o_result    (o_result),
    .o_zero      (o_zero),
    .o_illegal   (o_illegal)
  );

  // clock / reset
  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // reference model: plain arithmetic on the op definitions
  function automatic void ref_alu(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] r, output logic ill, output int lat);
    int sh;
    sh  = int'(b[4:0]);
    r   = 32'h0;
    ill = 1'b0;
    lat = 1;
    case (c)
      4'd0:  r = a + b;
      4'd1:  r = a - b;
      4'd2:  begin r = a << sh; lat = 1 + sh; end
      4'd3:  r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd4:  r = (a < b) ? 32'd1 : 32'd0;
      4'd5:  r = a ^ b;
      4'd6:  begin r = a >> sh; lat = 1 + sh; end
      4'd7:  begin r = 32'($signed(a) >>> sh); lat = 1 + sh; end
      4'd8:  r = a | b;
      4'd9:  r = a & b;
      4'd10: r = b;
      4'd11: r = a + b;
      default: ill = 1'b1;
    endcase
  endfunction

  // driver: issue one op, measure latency, optionally stall, then hand off.
  // Entered and left at a falling edge with the DUT in IDLE.
  task automatic run_op(input string name, input logic [3:0] ctrl, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_res, input logic exp_ill,
                        input int exp_lat, input int stall);
    int lat;
    bit busy_ok;
    bit stable;
    logic [31:0] exp_r;
    exp_q.push_back(exp_res);
    chk({name, "_ready_before"}, 32'(o_op_ready), 32'd1);
    i_op_valid = 1'b1;
    i_alu_ctrl = ctrl;
    i_op_a     = a;
    i_op_b     = b;
    @(negedge i_clk);
    i_op_valid = 1'b0;
    lat = 1;
    busy_ok = 1'b1;
    while (!o_res_valid && lat < 80) begin
      if (o_op_ready !== 1'b0) busy_ok = 1'b0;
      @(negedge i_clk);
      lat++;
    end
    if (o_op_ready !== 1'b0) busy_ok = 1'b0;
    exp_r = exp_q.pop_front();
    chk({name, "_latency"}, 32'(lat), 32'(exp_lat));
    chk({name, "_result"}, o_result, exp_r);
    chk({name, "_zero"}, 32'(o_zero), 32'(exp_r == 32'h0));
    chk({name, "_illegal"}, 32'(o_illegal), 32'(exp_ill));
    chk({name, "_busy"}, 32'(busy_ok), 32'd1);
    if (stall > 0) begin
      stable = 1'b1;
      for (int i = 0; i < stall; i++) begin
        @(negedge i_clk);
        if (o_res_valid !== 1'b1 || o_result !== exp_r || o_op_ready !== 1'b0 ||
            o_illegal !== exp_ill) stable = 1'b0;
      end
      chk({name, "_stall_stable"}, 32'(stable), 32'd1);
    end
    i_res_ready = 1'b1;
    @(negedge i_clk);
    i_res_ready = 1'b0;
    chk({name, "_handoff"}, {30'd0, o_res_valid, o_op_ready}, 32'b01);
  endtask

  typedef struct {
    string       name;
    logic [3:0]  ctrl;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        ill;
    int          lat;
  } vec_t;

  vec_t vecs[$];

  initial begin
    logic [31:0] r;
    logic        ill;
    int          lat;
    bit          never;
    logic [3:0]  c;
    logic [31:0] a;
    logic [31:0] b;

    vecs.push_back('{"add_ovf",   4'd0,  32'h7FFFFFFF, 32'h1,        32'h80000000, 1'b0, 1});
    vecs.push_back('{"sub_zero",  4'd1,  32'd5,        32'd5,        32'h0,        1'b0, 1});
    vecs.push_back('{"slt",       4'd3,  32'hFFFFFFFF, 32'h1,        32'h1,        1'b0, 1});
    vecs.push_back('{"sltu",      4'd4,  32'hFFFFFFFF, 32'h1,        32'h0,        1'b0, 1});
    vecs.push_back('{"sra31",     4'd7,  32'h80000000, 32'd31,       32'hFFFFFFFF, 1'b0, 32});
    vecs.push_back('{"sll0",      4'd2,  32'h1234,     32'h0,        32'h1234,     1'b0, 1});
    vecs.push_back('{"srl4",      4'd6,  32'h80000000, 32'd4,        32'h08000000, 1'b0, 5});
    vecs.push_back('{"sll_hib",   4'd2,  32'h1,        32'hFFFFFFE5, 32'h20,       1'b0, 6});
    vecs.push_back('{"and",       4'd9,  32'hF0F0,     32'hFF00,     32'hF000,     1'b0, 1});
    vecs.push_back('{"or",        4'd8,  32'hF0F0,     32'h0F0F,     32'hFFFF,     1'b0, 1});
    vecs.push_back('{"lui",       4'd10, 32'h12345678, 32'hABCDE000, 32'hABCDE000, 1'b0, 1});
    vecs.push_back('{"auipc",     4'd11, 32'h1000,     32'h20,       32'h1020,     1'b0, 1});
    vecs.push_back('{"illegal13", 4'd13, 32'h5,        32'h6,        32'h0,        1'b1, 1});
    vecs.push_back('{"illegal15", 4'd15, 32'hFFFF,     32'h1,        32'h0,        1'b1, 1});
    vecs.push_back('{"sra_pos",   4'd7,  32'h40000000, 32'd3,        32'h08000000, 1'b0, 4});

    i_rst_n     = 1'b0;
    i_op_valid  = 1'b0;
    i_alu_ctrl  = 4'd0;
    i_op_a      = 32'h0;
    i_op_b      = 32'h0;
    i_flush     = 1'b0;
    i_res_ready = 1'b0;
    repeat (2) @(negedge i_clk);
    chk("reset_outputs", {27'd0, o_op_ready, o_res_valid, o_zero, o_illegal, 1'b0},
        {27'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0});
    chk("reset_result", o_result, 32'h0);
    i_rst_n = 1'b1;
    @(negedge i_clk);

    // directed table
    foreach (vecs[i])
      run_op(vecs[i].name, vecs[i].ctrl, vecs[i].a, vecs[i].b, vecs[i].res, vecs[i].ill,
             vecs[i].lat, 0);

    // back-pressure on an XOR result
    run_op("xor_stall", 4'd5, 32'hAAAA5555, 32'hFFFF0000, 32'h55555555, 1'b0, 1, 5);

    // flush at T+3 of SRL by 10
    chk("flush_ready_before", 32'(o_op_ready), 32'd1);
    i_op_valid = 1'b1; i_alu_ctrl = 4'd6; i_op_a = 32'hFFFF0000; i_op_b = 32'd10;
    @(negedge i_clk);
    i_op_valid = 1'b0;
    repeat (2) @(negedge i_clk);
    i_flush = 1'b1;
    @(negedge i_clk);
    i_flush = 1'b0;
    chk("flush_shift_idle", {30'd0, o_res_valid, o_op_ready}, 32'b01);
    never = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge i_clk);
      if (o_res_valid !== 1'b0) never = 1'b0;
    end
    chk("flush_no_result", 32'(never), 32'd1);
    run_op("and_after_flush", 4'd9, 32'hF0F0, 32'hFF00, 32'hF000, 1'b0, 1, 0);

    // flush wins over a request in IDLE
    i_op_valid = 1'b1; i_flush = 1'b1; i_alu_ctrl = 4'd0; i_op_a = 32'd1; i_op_b = 32'd1;
    @(negedge i_clk);
    i_op_valid = 1'b0; i_flush = 1'b0;
    chk("flush_idle_no_accept", {30'd0, o_res_valid, o_op_ready}, 32'b01);

    // flush while a result waits in DONE
    i_op_valid = 1'b1; i_alu_ctrl = 4'd0; i_op_a = 32'd3; i_op_b = 32'd4;
    @(negedge i_clk);
    i_op_valid = 1'b0;
    chk("flush_done_valid", 32'(o_res_valid), 32'd1);
    i_flush = 1'b1;
    @(negedge i_clk);
    i_flush = 1'b0;
    chk("flush_done_idle", {30'd0, o_res_valid, o_op_ready}, 32'b01);

    // reset in the middle of a shift
    run_op("lui_pre_reset", 4'd10, 32'h0, 32'h55, 32'h55, 1'b0, 1, 0);
    i_op_valid = 1'b1; i_alu_ctrl = 4'd2; i_op_a = 32'h3; i_op_b = 32'd20;
    @(negedge i_clk);
    i_op_valid = 1'b0;
    repeat (3) @(negedge i_clk);
    i_rst_n = 1'b0;
    @(negedge i_clk);
    i_rst_n = 1'b1;
    chk("midshift_reset_flags", {28'd0, o_op_ready, o_res_valid, o_zero, o_illegal},
        {28'd0, 1'b1, 1'b0, 1'b1, 1'b0});
    chk("midshift_reset_result", o_result, 32'h0);
    @(negedge i_clk);

    // random stimulus against the model
    for (int i = 0; i < 40; i++) begin
      c = 4'($urandom_range(0, 15));
      a = $urandom;
      b = $urandom;
      if ($urandom_range(0, 3) == 0) b = a;
      ref_alu(c, a, b, r, ill, lat);
      run_op($sformatf("rand%0d_op%0d", i, c), c, a, b, r, ill, lat, $urandom_range(0, 3));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  // global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", n_errors);
    $fatal(1, "watchdog");
  end

endmodule
